// File: rtl/demo.sv
// Soda vending FSM: 20-cent price, nickel/dime/quarter coins, registered vend pulse and change.
// Optional saturating vend counter on vend_cnt_o when DEMO_VEND_COUNT_EN is defined.
module demo (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       nickle_i,
  input  logic       dime_i,
  input  logic       quarter_i,
  output logic       soda_o,
  output logic [4:0] change_o
`ifdef DEMO_VEND_COUNT_EN
  ,
  output logic [7:0] vend_cnt_o
`endif
);

  typedef enum logic [1:0] {
    CR0  = 2'd0,
    CR5  = 2'd1,
    CR10 = 2'd2,
    CR15 = 2'd3
  } state_t;

  localparam logic [5:0] PRICE = 6'd20;

  state_t     state_q;
  logic       soda_q;
  logic [4:0] change_q;

  logic [2:0] coins;
  logic       one_coin_d;
  logic [5:0] sum_d;
  logic       vend_d;

  function automatic logic [5:0] coin_value(input logic [2:0] c);
    logic [5:0] v;
    v = 6'd0;
    if (c[0]) v = 6'd5;
    if (c[1]) v = 6'd10;
    if (c[2]) v = 6'd25;
    return v;
  endfunction

  function automatic logic [5:0] credit_value(input state_t s);
    logic [5:0] v;
    case (s)
      CR5:     v = 6'd5;
      CR10:    v = 6'd10;
      CR15:    v = 6'd15;
      default: v = 6'd0;
    endcase
    return v;
  endfunction

  function automatic state_t credit_state(input logic [5:0] cents);
    state_t s;
    case (cents)
      6'd5:    s = CR5;
      6'd10:   s = CR10;
      6'd15:   s = CR15;
      default: s = CR0;
    endcase
    return s;
  endfunction

  // Sum never exceeds 40, so the remainder always fits in 5 bits.
  function automatic logic [4:0] change_of(input logic [5:0] cents);
    logic [5:0] r;
    r = cents - PRICE;
    return r[4:0];
  endfunction

  assign coins      = {quarter_i, dime_i, nickle_i};
  assign one_coin_d = $onehot(coins);
  assign sum_d      = credit_value(state_q) + coin_value(coins);
  assign vend_d     = one_coin_d && (sum_d >= PRICE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CR0;
      soda_q   <= 1'b0;
      change_q <= 5'd0;
    end else begin
      soda_q   <= 1'b0;
      change_q <= 5'd0;
      if (one_coin_d) begin
        if (vend_d) begin
          state_q  <= CR0;
          soda_q   <= 1'b1;
          change_q <= change_of(sum_d);
        end else begin
          state_q  <= credit_state(sum_d);
        end
      end
    end
  end

  assign soda_o   = soda_q;
  assign change_o = change_q;

`ifdef DEMO_VEND_COUNT_EN
  logic [7:0] vend_cnt_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vend_cnt_q <= 8'd0;
    end else if (vend_d) begin
      vend_cnt_q <= sat_inc8(vend_cnt_q);
    end
  end

  assign vend_cnt_o = vend_cnt_q;
`endif

endmodule

// File: tb/tb_demo.sv
// Directed bench for the soda vending FSM: vector table plus long quarter-stream sequence.
module tb_demo;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       nickle_i = 1'b0;
  logic       dime_i = 1'b0;
  logic       quarter_i = 1'b0;
  logic       soda_o;
  logic [4:0] change_o;
`ifdef DEMO_VEND_COUNT_EN
  logic [7:0] vend_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  demo dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .nickle_i  (nickle_i),
    .dime_i    (dime_i),
    .quarter_i (quarter_i),
    .soda_o    (soda_o),
    .change_o  (change_o)
`ifdef DEMO_VEND_COUNT_EN
    ,
    .vend_cnt_o(vend_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic       n;
    logic       d;
    logic       q;
    logic       soda;
    logic [4:0] chg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic n, input logic d, input logic q,
                     input logic s, input logic [4:0] c);
    vec_t v;
    v.rst = r; v.n = n; v.d = d; v.q = q; v.soda = s; v.chg = c;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name, input int idx,
                           input logic exp_s, input logic [4:0] exp_c);
    checks++;
    if (soda_o !== exp_s || change_o !== exp_c) begin
      errors++;
      $display("FAIL %s[%0d]: soda=%b change=%0d, expected soda=%b change=%0d",
               name, idx, soda_o, change_o, exp_s, exp_c);
    end
  endtask

`ifdef DEMO_VEND_COUNT_EN
  task automatic check_cnt(input string name, input int idx, input int exp_cnt);
    checks++;
    if (vend_cnt_o !== exp_cnt[7:0]) begin
      errors++;
      $display("FAIL %s[%0d]: vend_cnt=%0d, expected %0d", name, idx, vend_cnt_o, exp_cnt);
    end
  endtask
`endif

  // One cycle: drive inputs, let the edge sample them, then look 1 ns later.
  task automatic step(input logic r, input logic n, input logic d, input logic q);
    rst_i = r; nickle_i = n; dime_i = d; quarter_i = q;
    @(posedge clk_i);
    #1;
  endtask

  int cnt_exp;

  initial begin
    //   rst n d q   soda chg
    add(1, 0,0,0,  0, 0);   // reset
    add(0, 1,0,0,  0, 0);   // 5
    add(0, 1,0,0,  0, 0);   // 10
    add(0, 0,1,0,  1, 0);   // 20 -> vend, change 0
    add(0, 0,0,1,  1, 5);   // straight after vend, quarter from CR0
    add(0, 1,0,0,  0, 0);   // 5
    add(0, 0,0,1,  1, 10);  // 30
    add(0, 0,1,0,  0, 0);   // 10
    add(0, 0,0,1,  1, 15);  // 35
    add(0, 0,1,0,  0, 0);   // 10
    add(0, 1,0,0,  0, 0);   // 15
    add(0, 0,0,1,  1, 20);  // 40, max change
    add(0, 1,1,0,  0, 0);   // two coins: ignored
    add(0, 0,1,0,  0, 0);   // 10, no vend
    add(0, 0,0,0,  0, 0);   // idle holds 10
    add(0, 0,1,0,  1, 0);   // 20
    add(0, 1,1,1,  0, 0);   // three coins: ignored
    add(0, 0,1,0,  0, 0);   // 10
    add(0, 1,0,0,  0, 0);   // 15
    add(1, 0,0,1,  0, 0);   // reset beats quarter
    add(0, 0,1,0,  0, 0);   // 10 proves credit was cleared
    add(0, 0,1,0,  1, 0);   // 20
    add(0, 1,0,0,  0, 0);   // held nickel: 5
    add(0, 1,0,0,  0, 0);   // 10
    add(0, 1,0,0,  0, 0);   // 15
    add(0, 1,0,0,  1, 0);   // 20
    add(0, 0,1,0,  0, 0);   // 10
    add(0, 1,0,0,  0, 0);   // 15
    add(0, 0,1,0,  1, 5);   // 25
    add(0, 0,1,1,  0, 0);   // dime+quarter ignored
    add(0, 0,0,1,  1, 5);   // 25 from CR0
    add(1, 0,0,0,  0, 0);   // reset during vend cycle clears outputs
    add(0, 0,0,0,  0, 0);   // vend not repeated

    cnt_exp = 0;
    @(negedge clk_i);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].n, vecs[i].d, vecs[i].q);
      check_out("vec", i, vecs[i].soda, vecs[i].chg);
      if (vecs[i].rst) cnt_exp = 0;
      else if (vecs[i].soda && cnt_exp < 255) cnt_exp++;
`ifdef DEMO_VEND_COUNT_EN
      check_cnt("vec_cnt", i, cnt_exp);
`endif
    end

    // Long quarter stream: vend every cycle, counter saturates.
    step(1, 0, 0, 0);
    check_out("qs_rst", 0, 1'b0, 5'd0);
    cnt_exp = 0;
    for (int k = 1; k <= 300; k++) begin
      step(0, 0, 0, 1);
      check_out("qs", k, 1'b1, 5'd5);
      if (cnt_exp < 255) cnt_exp++;
`ifdef DEMO_VEND_COUNT_EN
      check_cnt("qs_cnt", k, cnt_exp);
`endif
    end
    step(0, 0, 0, 0);
    check_out("qs_idle", 0, 1'b0, 5'd0);
`ifdef DEMO_VEND_COUNT_EN
    check_cnt("qs_idle_cnt", 0, 255);
    step(1, 0, 0, 0);
    check_cnt("qs_cnt_rst", 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demo.md
DEMO -- requirements
Module: demo

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk_i and rst_i.
REQ-002 The block SHALL have no parameters; soda price is fixed at 20 cents.
REQ-003 clk_i  input  1  clock; all state updates and all inputs sampled on the rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 nickle_i  input  1  level; high in a sampled cycle = one 5-cent coin.
REQ-006 dime_i  input  1  level; high in a sampled cycle = one 10-cent coin.
REQ-007 quarter_i  input  1  level; high in a sampled cycle = one 25-cent coin.
REQ-008 soda_o  output  1  registered; high for exactly one cycle per vend.
REQ-009 change_o  output  5  registered; change in cents, valid only while soda_o is high, 0 otherwise.
REQ-010 vend_cnt_o  output  8  registered vend counter; present only when DEMO_VEND_COUNT_EN is defined.

Function
REQ-011 Credit SHALL be held as an FSM with states CR0, CR5, CR10 and CR15 (0/5/10/15 cents accumulated).
REQ-012 The block SHALL count each rising edge with exactly one coin input high as one coin; a coin held high for N cycles SHALL count as N coins.
REQ-013 A cycle with two or more coin inputs high SHALL be ignored: no credit change, soda_o=0, change_o=0 next cycle.
REQ-014 With no coin input high, the state SHALL be held and soda_o/change_o SHALL be 0 next cycle.
REQ-015 Sum = credit + coin value; if sum < 20, the next state SHALL be CR<sum>, with soda_o=0 and change_o=0.
REQ-016 If sum >= 20, the next state SHALL be CR0, with soda_o=1 and change_o=sum-20 in the following cycle (latency one clock).
REQ-017 Maximum sum is 40 (CR15 + quarter), so change_o SHALL range 0..20 and never overflow 5 bits.
REQ-018 A coin in the cycle immediately after a vend SHALL start a new transaction from CR0; no dead cycle is required.
REQ-019 soda_o and change_o SHALL be driven directly from flops, with no combinational path from the coin inputs.

Reset
REQ-020 When rst_i=1 at a rising edge, the state SHALL become CR0 and soda_o, change_o (and vend_cnt_o if present) SHALL become 0.
REQ-021 Reset SHALL take priority over coins in the same cycle; that cycle's coins SHALL be discarded.
REQ-022 Reset asserted during a vend cycle SHALL clear soda_o/change_o at that edge; the pending vend is not repeated.

Configuration
REQ-023 With DEMO_VEND_COUNT_EN defined, vend_cnt_o SHALL increment by 1 on every vend and SHALL saturate at 255.
REQ-024 Without DEMO_VEND_COUNT_EN, the vend_cnt_o port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-025 Reset, then nickel, nickel, dime (one cycle each) -> soda_o=1, change_o=0 in the cycle after the dime; credit back to CR0.
REQ-026 From CR0, quarter -> soda_o=1, change_o=5 next cycle.
REQ-027 Nickel then quarter -> change_o=10; dime then quarter -> change_o=15; dime, nickel, quarter -> change_o=20.
REQ-028 Nickel+dime high in the same cycle -> no credit change; a following dime from CR0 gives no vend (credit 10).
REQ-029 CR15, then rst_i=1 together with a quarter -> no vend, CR0, all outputs 0.
REQ-030 With DEMO_VEND_COUNT_EN, 300 consecutive quarter cycles -> vend_cnt_o saturates at 255 and soda_o pulses every cycle.
